rdid_button_ctrl: RTL and testbench

- Push-button-triggered controller for the SPI flash Read-ID (RDID) transaction.
- Debounces a raw button and converts each press into a single-cycle trigger.
- On each trigger, sequences one SPI mode-0 transfer: command byte out, then 3 ID bytes in. Latches the ID for LEDs/display.
- Sits between the board button and the flash SPI pins. It is the only SPI master during RDID.

---
 rtl/rdid_pkg.sv | 17 +
 rtl/rdid_press_detect.sv | 48 ++++
 rtl/rdid_button_ctrl.sv | 159 +++++++++++++++
 tb/tb_rdid_button_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rdid_pkg.sv
// Shared types and constants for the push-button SPI flash Read-ID controller.
package rdid_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    SHIFT,
    CS_HOLD,
    GAP
  } rdid_state_t;

  localparam logic [7:0] RDID_CMD_DEFAULT = 8'h9F;
  localparam int         ID_BYTES         = 3;
  localparam int         CMD_BITS         = 8;
  localparam int         TOTAL_BITS       = 32;

endpackage

// File: rtl/rdid_press_detect.sv
// Button front end: 2-flop synchronizer, stability-count debounce, and a
// single-cycle pulse on each debounced press (releases produce nothing).
module rdid_press_detect
  import rdid_pkg::*;
#(
  parameter int DEBOUNCE_CNT = 65535
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic press
);

  localparam int            CW       = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CNT - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic          level_d;
  logic [CW-1:0] cnt;

  // Any sample agreeing with the current level restarts the stability count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1   <= btn_in;
      sync2   <= sync1;
      level_d <= level;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign press = level & ~level_d;

endmodule

// File: rtl/rdid_button_ctrl.sv
// Button-triggered SPI mode-0 RDID sequencer: sends the command byte, captures
// the 3-byte ID. Defining RDID_ID_CHECK_EN adds the id_match output.
module rdid_button_ctrl
  import rdid_pkg::*;
#(
  parameter int                  CLK_DIV      = 4,
  parameter int                  DEBOUNCE_CNT = 65535,
  parameter logic [CMD_BITS-1:0] RDID_CMD     = RDID_CMD_DEFAULT
`ifdef RDID_ID_CHECK_EN
  ,
  parameter logic [ID_BYTES*8-1:0] EXPECTED_ID = 24'h20BA18
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_in,
  output logic       spi_sclk,
  output logic       spi_cs_n,
  output logic       spi_mosi,
  input  logic       spi_miso,
  output logic       busy,
  output logic       id_valid,
  output logic [7:0] id_manuf,
  output logic [7:0] id_type,
  output logic [7:0] id_cap
`ifdef RDID_ID_CHECK_EN
  ,
  output logic       id_match
`endif
);

  localparam int            DW       = $clog2(CLK_DIV + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam int            BW       = $clog2(TOTAL_BITS);
  localparam logic [BW-1:0] BIT_LAST = BW'(TOTAL_BITS - 1);

  rdid_state_t             state;
  rdid_state_t             state_next;
  logic [DW-1:0]           div_cnt;
  logic [BW-1:0]           bit_cnt;
  logic [CMD_BITS-1:0]     cmd_sr;
  logic [ID_BYTES*8-1:0]   rx_sr;
  logic                    press;
  logic                    div_done;
  logic                    start;
  logic                    rise;
  logic                    fall;
  logic                    finish;
  logic                    done;

  rdid_press_detect #(
    .DEBOUNCE_CNT(DEBOUNCE_CNT)
  ) u_press (
    .clk   (clk),
    .reset (reset),
    .btn_in(btn_in),
    .press (press)
  );

  assign div_done = (div_cnt == DIV_LAST);
  assign spi_mosi = cmd_sr[CMD_BITS-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Every phase lasts CLK_DIV cycles; strobes tell the datapath what the phase end means.
  always_comb begin
    state_next = state;
    start      = 1'b0;
    rise       = 1'b0;
    fall       = 1'b0;
    finish     = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (press) begin
          state_next = CS_SETUP;
          start      = 1'b1;
        end
      end
      CS_SETUP: if (div_done) state_next = SHIFT;
      SHIFT: begin
        if (div_done) begin
          if (!spi_sclk) begin
            rise = 1'b1;
          end else begin
            fall = 1'b1;
            if (bit_cnt == BIT_LAST) state_next = CS_HOLD;
          end
        end
      end
      CS_HOLD: begin
        if (div_done) begin
          finish     = 1'b1;
          state_next = GAP;
        end
      end
      GAP: begin
        if (div_done) begin
          done       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // The receive register is only ID-wide, so command-phase bits fall off the top.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt  <= '0;
      bit_cnt  <= '0;
      spi_sclk <= 1'b0;
      spi_cs_n <= 1'b1;
      busy     <= 1'b0;
      cmd_sr   <= '0;
      rx_sr    <= '0;
      id_valid <= 1'b0;
      id_manuf <= '0;
      id_type  <= '0;
      id_cap   <= '0;
    end else begin
      div_cnt <= (state == IDLE || div_done) ? '0 : div_cnt + 1'b1;
      if (start) begin
        spi_cs_n <= 1'b0;
        busy     <= 1'b1;
        id_valid <= 1'b0;
        cmd_sr   <= RDID_CMD;
        bit_cnt  <= '0;
      end
      if (rise) begin
        spi_sclk <= 1'b1;
        rx_sr    <= {rx_sr[ID_BYTES*8-2:0], spi_miso};
      end
      if (fall) begin
        spi_sclk <= 1'b0;
        cmd_sr   <= {cmd_sr[CMD_BITS-2:0], 1'b0};
        bit_cnt  <= bit_cnt + 1'b1;
      end
      if (finish) begin
        spi_cs_n                      <= 1'b1;
        id_valid                      <= 1'b1;
        {id_manuf, id_type, id_cap}   <= rx_sr;
      end
      if (done) busy <= 1'b0;
    end
  end

`ifdef RDID_ID_CHECK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       id_match <= 1'b0;
    else if (start)  id_match <= 1'b0;
    else if (finish) id_match <= (rx_sr == EXPECTED_ID);
  end
`endif

endmodule

// File: tb/tb_rdid_button_ctrl.sv
// Self-checking bench for rdid_button_ctrl with a bit-level SPI flash model.
// Build with RDID_ID_CHECK_EN defined to also cover id_match.
module tb_rdid_button_ctrl;

  localparam int          CLK_DIV      = 2;
  localparam int          DEBOUNCE_CNT = 16;
  localparam int          CLK_PERIOD   = 10;
  // A transfer keeps cs_n low for setup + 32 SCLK periods + hold.
  localparam int          EXP_CS_LOW   = (1 + 2 * 32 + 1) * CLK_DIV;
  localparam logic [23:0] REF_ID       = 24'h20BA18;

  logic       clk;
  logic       reset;
  logic       btn_in;
  logic       spi_sclk;
  logic       spi_cs_n;
  logic       spi_mosi;
  logic       spi_miso;
  logic       busy;
  logic       id_valid;
  logic [7:0] id_manuf;
  logic [7:0] id_type;
  logic [7:0] id_cap;
`ifdef RDID_ID_CHECK_EN
  logic       id_match;
`endif

  rdid_button_ctrl #(
    .CLK_DIV     (CLK_DIV),
    .DEBOUNCE_CNT(DEBOUNCE_CNT),
    .RDID_CMD    (8'h9F)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .btn_in  (btn_in),
    .spi_sclk(spi_sclk),
    .spi_cs_n(spi_cs_n),
    .spi_mosi(spi_mosi),
    .spi_miso(spi_miso),
    .busy    (busy),
    .id_valid(id_valid),
    .id_manuf(id_manuf),
    .id_type (id_type),
    .id_cap  (id_cap)
`ifdef RDID_ID_CHECK_EN
    ,
    .id_match(id_match)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #(CLK_PERIOD / 2) clk = ~clk;
  end

  int          vectors     = 0;
  int          miscompares = 0;
  logic [23:0] flash_id    = '0;
  int          rise_cnt    = 0;
  logic [7:0]  mosi_cap    = '0;
  bit          cs_prev     = 1'b1;
  int          tx_count    = 0;
  int          cs_low_cnt  = 0;
  int          busy_after  = 0;
  int          sclk_bad    = 0;
  bit          mon_prev_cs = 1'b1;
  time         t_fall      = 0;
  logic [23:0] exp_q[$];

  // Flash side: records the command on SCLK rise, shifts the ID out on SCLK fall,
  // and drives junk on miso while the command is still going in.
  initial spi_miso = 1'b0;
  always @(spi_sclk or spi_cs_n) begin
    logic [31:0] r;
    r = $urandom;
    if (spi_cs_n) begin
      cs_prev = 1'b1;
    end else if (cs_prev) begin
      cs_prev  = 1'b0;
      rise_cnt = 0;
      mosi_cap = '0;
      spi_miso = r[0];
    end else if (spi_sclk) begin
      if (rise_cnt < 8) mosi_cap = {mosi_cap[6:0], spi_mosi};
      rise_cnt++;
    end else begin
      if (rise_cnt >= 8 && rise_cnt < 32) spi_miso = flash_id[31-rise_cnt];
      else                                spi_miso = r[0];
    end
  end

  always @(negedge clk) begin
    if (!spi_cs_n && mon_prev_cs) begin
      tx_count++;
      cs_low_cnt = 1;
      busy_after = 0;
      sclk_bad   = 0;
    end else if (!spi_cs_n) begin
      cs_low_cnt++;
    end
    if (spi_cs_n && busy)     busy_after++;
    if (spi_sclk && spi_cs_n) sclk_bad++;
    mon_prev_cs = spi_cs_n;
  end

  always @(negedge spi_cs_n) t_fall = $time;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic wait_cs_low(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!spi_cs_n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Clean press of the button; returns once the transfer and release have settled.
  task automatic applyStimulus(input logic [23:0] id);
    bit ok1, ok2;
    flash_id = id;
    btn_in   = 1'b1;
    wait_cs_low(80, ok1);
    btn_in   = 1'b0;
    wait_idle(400, ok2);
    checkOutput("tx_completed", 32'(ok1 & ok2), 32'd1);
    repeat (40) @(negedge clk);
  endtask

  task automatic check_transfer(input string tag, input logic [23:0] exp_id, input logic exp_match);
    checkOutput({tag, "_id_valid"}, 32'(id_valid), 32'd1);
    checkOutput({tag, "_id_manuf"}, 32'(id_manuf), 32'(exp_id[23:16]));
    checkOutput({tag, "_id_type"},  32'(id_type),  32'(exp_id[15:8]));
    checkOutput({tag, "_id_cap"},   32'(id_cap),   32'(exp_id[7:0]));
    checkOutput({tag, "_cs_low_cycles"}, cs_low_cnt, EXP_CS_LOW);
    checkOutput({tag, "_mosi_cmd"}, 32'(mosi_cap), 32'h9F);
    checkOutput({tag, "_sclk_rises"}, rise_cnt, 32);
    checkOutput({tag, "_busy_after_cs"}, busy_after, CLK_DIV);
    checkOutput({tag, "_sclk_high_cs_high"}, sclk_bad, 0);
`ifdef RDID_ID_CHECK_EN
    checkOutput({tag, "_id_match"}, 32'(id_match), 32'(exp_match));
`else
    if (exp_match === 1'bx) $display("[TB] unexpected X match flag");
`endif
  endtask

  typedef struct {
    logic [23:0] flash_id;
    logic [7:0]  exp_manuf;
    logic [7:0]  exp_type;
    logic [7:0]  exp_cap;
    logic        exp_match;
  } vec_t;

  initial begin
    vec_t        table_v[4];
    bit          ok;
    int          tx_base;
    int          lows;
    time         t_last;
    time         delta;
    logic [31:0] r;
    logic [23:0] exp_id;

    table_v[0] = '{24'h20BA18, 8'h20, 8'hBA, 8'h18, 1'b1};
    table_v[1] = '{24'hEF4018, 8'hEF, 8'h40, 8'h18, 1'b0};
    table_v[2] = '{24'h000000, 8'h00, 8'h00, 8'h00, 1'b0};
    table_v[3] = '{24'hFFFFFF, 8'hFF, 8'hFF, 8'hFF, 1'b0};

    reset  = 1'b1;
    btn_in = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_cs_n",     32'(spi_cs_n), 32'd1);
    checkOutput("reset_sclk",     32'(spi_sclk), 32'd0);
    checkOutput("reset_mosi",     32'(spi_mosi), 32'd0);
    checkOutput("reset_busy",     32'(busy),     32'd0);
    checkOutput("reset_id_valid", 32'(id_valid), 32'd0);
    checkOutput("reset_id",       32'({id_manuf, id_type, id_cap}), 32'd0);
`ifdef RDID_ID_CHECK_EN
    checkOutput("reset_id_match", 32'(id_match), 32'd0);
`endif
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // Bouncing press: ten 3-unit edges, then a clean hold.
    flash_id = REF_ID;
    tx_base  = tx_count;
    @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) begin
      btn_in = ~btn_in;
      #3;
    end
    btn_in = 1'b1;
    t_last = $time;
    wait_cs_low(100, ok);
    checkOutput("bounce_cs_fall", 32'(ok), 32'd1);
    delta = t_fall - t_last;
    checkOutput("debounce_latency_18_20_cycles",
                32'(delta >= (DEBOUNCE_CNT + 2) * CLK_PERIOD && delta <= (DEBOUNCE_CNT + 4) * CLK_PERIOD), 32'd1);
    repeat (500) @(negedge clk);
    checkOutput("bounce_single_tx", tx_count - tx_base, 1);
    check_transfer("bounce", REF_ID, 1'b1);
    btn_in = 1'b0;
    repeat (40) @(negedge clk);

    // Second press lands around cycle 40 of the transfer and must be dropped.
    flash_id = 24'hEF4018;
    tx_base  = tx_count;
    btn_in   = 1'b1;
    wait_cs_low(80, ok);
    checkOutput("busy_test_cs_fall", 32'(ok), 32'd1);
    checkOutput("new_tx_clears_id_valid", 32'(id_valid), 32'd0);
    checkOutput("old_id_kept", 32'(id_manuf), 32'h20);
    btn_in = 1'b0;
    repeat (24) @(negedge clk);
    btn_in = 1'b1;
    wait_idle(400, ok);
    checkOutput("busy_test_idle", 32'(ok), 32'd1);
    repeat (20) @(negedge clk);
    btn_in = 1'b0;
    repeat (200) @(negedge clk);
    checkOutput("busy_press_dropped", tx_count - tx_base, 1);
    check_transfer("busy_press", 24'hEF4018, 1'b0);

    // Reset during the 12th SCLK high phase aborts the transfer at once.
    flash_id = 24'h123456;
    btn_in   = 1'b1;
    wait_cs_low(80, ok);
    btn_in   = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rise_cnt >= 12) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput("reached_bit12", 32'(ok), 32'd1);
    checkOutput("sclk_high_before_reset", 32'(spi_sclk), 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("abort_cs_n", 32'(spi_cs_n), 32'd1);
    checkOutput("abort_sclk", 32'(spi_sclk), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_id_valid", 32'(id_valid), 32'd0);
    checkOutput("abort_id_cleared", 32'({id_manuf, id_type, id_cap}), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    applyStimulus(24'hC22017);
    check_transfer("after_abort", 24'hC22017, 1'b0);

    // A 10-cycle glitch is shorter than the debounce window.
    tx_base = tx_count;
    lows    = 0;
    btn_in  = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (!spi_cs_n) lows++;
    end
    btn_in = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (!spi_cs_n) lows++;
    end
    checkOutput("glitch_no_tx", tx_count - tx_base, 0);
    checkOutput("glitch_cs_stays_high", lows, 0);

    for (int i = 0; i < 4; i++) begin
      applyStimulus(table_v[i].flash_id);
      checkOutput($sformatf("vec%0d_manuf", i), 32'(id_manuf), 32'(table_v[i].exp_manuf));
      checkOutput($sformatf("vec%0d_type", i),  32'(id_type),  32'(table_v[i].exp_type));
      checkOutput($sformatf("vec%0d_cap", i),   32'(id_cap),   32'(table_v[i].exp_cap));
      check_transfer($sformatf("vec%0d", i), {table_v[i].exp_manuf, table_v[i].exp_type, table_v[i].exp_cap},
                     table_v[i].exp_match);
    end

    // Random IDs: the reference is simply the byte stream the flash returned.
    for (int i = 0; i < 6; i++) begin
      r = $urandom;
      exp_q.push_back(r[23:0]);
      repeat ($urandom_range(0, 30)) @(negedge clk);
      applyStimulus(r[23:0]);
      exp_id = exp_q.pop_front();
      check_transfer($sformatf("rand%0d", i), exp_id, exp_id == REF_ID);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
